// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong game blocks.
//   ctrl_state_t  - paddle controller mode (FREEZE / HUMAN / CPU)
//   ACTIVE_ROWS   - visible rows; row coordinates are $clog2(ACTIVE_ROWS) bits
//   ACTIVE_COLS   - visible columns
//   CLKS_PER_MOVE - clocks per paddle move tick
//   HEIGHT        - paddle height in rows
package pong_pkg;

  localparam int ACTIVE_ROWS   = 480;
  localparam int ACTIVE_COLS   = 640;
  localparam int CLKS_PER_MOVE = 250_000;
  localparam int HEIGHT        = 64;

  typedef enum logic [1:0] {
    FREEZE = 2'd0,
    HUMAN  = 2'd1,
    CPU    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: signals between the board/ball logic and one paddle_ctrl.
//   btn_up, btn_down - raw asynchronous buttons
//   game_active      - high while play is running
//   ball_y, paddle_y - ball top row and paddle top row
//   up, down         - registered move requests to the paddle
//   cpu_mode         - high while the CPU tracker drives the paddle
// Modports: master = board/ball side, slave = paddle_ctrl.
interface paddle_ctrl_if #(
  parameter int ACTIVE_ROWS = pong_pkg::ACTIVE_ROWS
);
  localparam int RW = $clog2(ACTIVE_ROWS);

  logic          btn_up;
  logic          btn_down;
  logic          game_active;
  logic [RW-1:0] ball_y;
  logic [RW-1:0] paddle_y;
  logic          up;
  logic          down;
  logic          cpu_mode;

  modport master (
    output btn_up, btn_down, game_active, ball_y, paddle_y,
    input  up, down, cpu_mode
  );

  modport slave (
    input  btn_up, btn_down, game_active, ball_y, paddle_y,
    output up, down, cpu_mode
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stability counter.
// The debounced output only follows the synchronized button after it has
// differed from the current debounced value for DEBOUNCE_CLKS consecutive
// samples; shorter glitches are dropped.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_btn      - raw asynchronous button
//   o_db       - debounced button
module btn_debounce #(
  parameter int DEBOUNCE_CLKS = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_db
);
  localparam int CW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // stability counter; any sample matching the debounced value restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_db  <= 1'b0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == CW'(DEBOUNCE_CLKS - 1)) begin
      r_db  <= r_sync2;
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_db = r_db;
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-paddle command source. Debounces the player's buttons and
// hands control to a CPU ball tracker after the player has been idle for
// IDLE_MOVES move ticks.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - paddle_ctrl_if.slave (buttons, game_active, ball_y,
//                paddle_y in; up, down, cpu_mode out)
// Optional feature macro PADDLE_CTRL_HANDICAP_EN: when defined the CPU only
// moves on alternate move ticks.
module paddle_ctrl #(
  parameter int CLKS_PER_MOVE = pong_pkg::CLKS_PER_MOVE,
  parameter int ACTIVE_ROWS   = pong_pkg::ACTIVE_ROWS,
  parameter int HEIGHT        = pong_pkg::HEIGHT,
  parameter int DEBOUNCE_CLKS = 500_000,
  parameter int IDLE_MOVES    = 2000,
  parameter int DEAD_BAND     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  paddle_ctrl_if.slave bus
);
  import pong_pkg::*;

  localparam int RW = $clog2(ACTIVE_ROWS);
  localparam int CW = RW + 1;
  localparam int TW = (CLKS_PER_MOVE > 1) ? $clog2(CLKS_PER_MOVE) : 1;
  localparam int IW = $clog2(IDLE_MOVES + 1);

  logic          w_db_up;
  logic          w_db_down;
  logic          w_act;
  logic          w_tick;
  logic          w_gate;
  logic [CW-1:0] w_center;
  logic          w_cpu_up;
  logic          w_cpu_down;
  logic          w_up_nxt;
  logic          w_down_nxt;
  ctrl_state_t   w_state_nxt;

  ctrl_state_t   r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [IW-1:0] r_idle;
  logic          r_up;
  logic          r_down;
  logic          r_cpu_mode;

  btn_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .i_btn (bus.btn_up),
    .o_db  (w_db_up)
  );

  btn_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_down (
    .clk   (clk),
    .rst_n (rst_n),
    .i_btn (bus.btn_down),
    .o_db  (w_db_down)
  );

  // both buttons held still counts as the player being present
  assign w_act  = w_db_up | w_db_down;
  assign w_tick = (r_tick_cnt == TW'(CLKS_PER_MOVE - 1));

  // free-running move tick counter, runs in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= {TW{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {TW{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // idle move counter, saturating at IDLE_MOVES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= {IW{1'b0}};
    end else if ((r_state == FREEZE) || w_act) begin
      r_idle <= {IW{1'b0}};
    end else if (w_tick && (r_idle != IW'(IDLE_MOVES))) begin
      r_idle <= r_idle + IW'(1);
    end else begin
      r_idle <= r_idle;
    end
  end

  // CPU tracker compares in one extra bit so the paddle centre cannot wrap
  assign w_center   = {1'b0, bus.paddle_y} + CW'(HEIGHT / 2);
  assign w_cpu_up   = (({1'b0, bus.ball_y} + CW'(DEAD_BAND)) < w_center);
  assign w_cpu_down = ({1'b0, bus.ball_y} > (w_center + CW'(DEAD_BAND)));

`ifdef PADDLE_CTRL_HANDICAP_EN
  logic r_toggle;
  logic w_toggle_nxt;

  // toggle restarts at 0 on CPU entry and flips on every tick while in CPU
  always_comb begin
    w_toggle_nxt = 1'b0;
    if (r_state != CPU) begin
      w_toggle_nxt = 1'b0;
    end else if (w_tick) begin
      w_toggle_nxt = ~r_toggle;
    end else begin
      w_toggle_nxt = r_toggle;
    end
  end

  // handicap toggle register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
    end else begin
      r_toggle <= w_toggle_nxt;
    end
  end

  assign w_gate = w_toggle_nxt;
`else
  assign w_gate = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FREEZE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; losing game_active beats every other transition
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.game_active) begin
      w_state_nxt = FREEZE;
    end else begin
      case (r_state)
        FREEZE:  w_state_nxt = HUMAN;
        HUMAN:   w_state_nxt = (r_idle == IW'(IDLE_MOVES)) ? CPU : HUMAN;
        CPU:     w_state_nxt = w_act ? HUMAN : CPU;
        default: w_state_nxt = FREEZE;
      endcase
    end
  end

  // FSM outputs, decoded from the state being entered so they land with it
  always_comb begin
    w_up_nxt   = 1'b0;
    w_down_nxt = 1'b0;
    case (w_state_nxt)
      FREEZE: begin
        w_up_nxt   = 1'b0;
        w_down_nxt = 1'b0;
      end
      HUMAN: begin
        w_up_nxt   = w_db_up & ~w_db_down;
        w_down_nxt = w_db_down & ~w_db_up;
      end
      CPU: begin
        w_up_nxt   = w_cpu_up & w_gate;
        w_down_nxt = w_cpu_down & w_gate;
      end
      default: begin
        w_up_nxt   = 1'b0;
        w_down_nxt = 1'b0;
      end
    endcase
  end

  // registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_cpu_mode <= 1'b0;
    end else begin
      r_up       <= w_up_nxt;
      r_down     <= w_down_nxt;
      r_cpu_mode <= (w_state_nxt == CPU);
    end
  end

  assign bus.up       = r_up;
  assign bus.down     = r_down;
  assign bus.cpu_mode = r_cpu_mode;
endmodule
